// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared RSA datapath constants and FSM encoding
package rsa_pkg;

  // Default operand/modulus width; Montgomery radix is 2^RSA_WIDTH.
  localparam int RSA_WIDTH = 256;

  // Iteration counter must be able to count 0..WIDTH, hence log2(WIDTH)+1 bits.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

  localparam int RSA_CNT_W = cnt_width(RSA_WIDTH);

  // Multiplier FSM encoding, kept as plain constants for legacy tools.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_LOOP  = 2'd1;
  localparam state_t ST_FINAL = 2'd2;

endpackage

// File: rtl/mont_mult_if.sv
// rtl/mont_mult_if.sv - start/done handshake and operand bus of the Montgomery multiplier
interface mont_mult_if #(
  parameter int WIDTH = rsa_pkg::RSA_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] N;
  logic [WIDTH-1:0] out;
  logic             out_ready;
  logic             busy;

  modport master (
    output start, A, B, N,
    input  out, out_ready, busy
  );

  modport slave (
    input  start, A, B, N,
    output out, out_ready, busy
  );
endinterface

// File: rtl/mont_step.sv
// rtl/mont_step.sv - one radix-2 Montgomery iteration, combinational
module mont_step
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic [WIDTH+1:0] m,
  input  logic             a_bit,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH+1:0] m_next
);
  // With m < 2N and B, N < 2^WIDTH the sum stays below 4N, so WIDTH+2 bits never overflow.
  logic [WIDTH+1:0] t_add;
  logic [WIDTH+1:0] t_red;

  // Add B when the multiplicand bit is set, make the sum even with N, then halve.
  always_comb begin
    t_add  = m + (a_bit ? {2'b00, b} : '0);
    t_red  = t_add[0] ? (t_add + {2'b00, n}) : t_add;
    m_next = t_red >> 1;
  end
endmodule

// File: rtl/mont_mult.sv
// rtl/mont_mult.sv - radix-2 bit-serial Montgomery multiplier: FSM, operand latches, output register
module mont_mult
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input logic        clk,
  input logic        reset,
  mont_mult_if.slave bus
);
  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;        // multiplicand, shifted right so bit 0 is the current bit
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH+1:0] m_q, m_d;        // accumulator, invariant m < 2N
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_ready_q, out_ready_d;
  logic             busy_q, busy_d;
  logic [WIDTH+1:0] step_m;

  mont_step #(.WIDTH(WIDTH)) u_step (
    .m      (m_q),
    .a_bit  (a_q[0]),
    .b      (b_q),
    .n      (n_q),
    .m_next (step_m)
  );

  // Next-state logic: latch on start, iterate one bit per cycle, then one conditional subtract.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    n_d         = n_q;
    m_d         = m_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_ready_d = 1'b0;
    busy_d      = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          n_d     = bus.N;
          m_d     = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_LOOP;
        end
      end
      ST_LOOP: begin
        m_d   = step_m;
        a_d   = a_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = ST_FINAL;
        end
      end
      ST_FINAL: begin
        // m < 2N, so one subtraction lands the result strictly below N.
        out_d       = WIDTH'((m_q >= {2'b00, n_q}) ? (m_q - {2'b00, n_q}) : m_q);
        out_ready_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any computation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      n_q         <= '0;
      m_q         <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      n_q         <= n_d;
      m_q         <= m_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_ready_q <= out_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_ready = out_ready_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mont_mult.sv
// tb/tb_mont_mult.sv - self-checking bench for mont_mult at WIDTH 8 and 256
module tb_mont_mult;

  logic clk = 1'b0;
  logic rst8;
  logic rst256;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mont_mult_if #(.WIDTH(8))   bus8 ();
  mont_mult_if #(.WIDTH(256)) bus256 ();

  mont_mult #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .reset (rst8),
    .bus   (bus8)
  );

  mont_mult #(.WIDTH(256)) dut256 (
    .clk   (clk),
    .reset (rst256),
    .bus   (bus256)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // A*B*2^-w mod N: reduce the plain product, then halve modulo N w times.
  function automatic logic [255:0] ref_mont(input logic [255:0] a, input logic [255:0] b,
                                            input logic [255:0] n, input int w);
    logic [511:0] p;
    p = (512'(a) * 512'(b)) % 512'(n);
    for (int k = 0; k < w; k++) begin
      if (p[0]) p = p + 512'(n);
      p = p >> 1;
    end
    return p[255:0];
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Called just after a rising edge; start is sampled on the next edge, then operands are scrambled.
  task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] n);
    bus8.start = 1'b1;
    bus8.A = a;
    bus8.B = b;
    bus8.N = n;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    bus8.A = 8'($urandom);
    bus8.B = 8'($urandom);
    bus8.N = 8'($urandom);
  endtask

  // Counts edges from the start sample to out_ready; optionally fires a stray start at edge inject_at.
  task automatic wait8(input int inject_at, output int lat, output int busy_cyc,
                       output logic [7:0] res, output bit timeout);
    lat      = 0;
    busy_cyc = bus8.busy ? 1 : 0;
    timeout  = 1'b0;
    while (1'b1) begin
      if (lat == inject_at) begin
        bus8.start = 1'b1;
        bus8.A = 8'd12;
        bus8.B = 8'd12;
        bus8.N = 8'd13;
      end else begin
        bus8.start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (bus8.out_ready) break;
      if (bus8.busy) busy_cyc++;
      if (lat >= 40) begin
        timeout = 1'b1;
        break;
      end
    end
    bus8.start = 1'b0;
    res = bus8.out;
  endtask

  task automatic run256(input logic [255:0] a, input logic [255:0] b, input logic [255:0] n,
                        output logic [255:0] res, output int lat);
    bus256.start = 1'b1;
    bus256.A = a;
    bus256.B = b;
    bus256.N = n;
    @(posedge clk); #1;
    bus256.start = 1'b0;
    bus256.A = rand256();
    bus256.B = rand256();
    bus256.N = rand256();
    lat = 0;
    while (1'b1) begin
      @(posedge clk); #1;
      lat++;
      if (bus256.out_ready || lat >= 400) break;
    end
    res = bus256.out;
  endtask

  initial begin
    int           lat;
    int           bc;
    int           pulses;
    bit           to;
    logic [7:0]   res8;
    logic [7:0]   a8, b8, n8;
    logic [255:0] a, b, n, m, res;
    logic [511:0] wide;

    bus8.start = 1'b0;
    bus8.A = '0;
    bus8.B = '0;
    bus8.N = '0;
    bus256.start = 1'b0;
    bus256.A = '0;
    bus256.B = '0;
    bus256.N = '0;
    rst8 = 1'b1;
    rst256 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out8", 256'(bus8.out), 256'd0);
    check("rst_ready8", 256'(bus8.out_ready), 256'd0);
    check("rst_busy8", 256'(bus8.busy), 256'd0);
    check("rst_out256", bus256.out, 256'd0);
    check("rst_busy256", 256'(bus256.busy), 256'd0);
    rst8 = 1'b0;
    rst256 = 1'b0;
    @(posedge clk); #1;

    // Basic case with latency and busy-window checks.
    launch8(8'd5, 8'd7, 8'd13);
    wait8(-1, lat, bc, res8, to);
    check("t1_out", 256'(res8), 256'd1);
    check("t1_latency", 256'(lat), 256'd9);
    check("t1_busy_cycles", 256'(bc), 256'd9);
    check("t1_timeout", 256'(to), 256'd0);
    @(posedge clk); #1;
    check("t1_ready_drop", 256'(bus8.out_ready), 256'd0);
    check("t1_out_hold", 256'(bus8.out), 256'd1);

    // Back-to-back: second start issued in the out_ready cycle.
    launch8(8'd9, 8'd9, 8'd13);
    wait8(-1, lat, bc, res8, to);
    check("b2b_first", 256'(res8), 256'd9);
    launch8(8'd12, 8'd12, 8'd13);
    check("b2b_ready_drop", 256'(bus8.out_ready), 256'd0);
    check("b2b_out_hold", 256'(bus8.out), 256'd9);
    check("b2b_accepted", 256'(bus8.busy), 256'd1);
    wait8(-1, lat, bc, res8, to);
    check("b2b_second", 256'(res8), 256'd3);
    check("b2b_latency", 256'(lat), 256'd9);

    // N = 255 edge operands.
    launch8(8'd0, 8'd200, 8'd255);
    wait8(-1, lat, bc, res8, to);
    check("n255_zero", 256'(res8), 256'd0);
    launch8(8'd254, 8'd254, 8'd255);
    wait8(-1, lat, bc, res8, to);
    check("n255_max", 256'(res8), 256'd1);

    // Stray start mid-LOOP must be ignored and not queued.
    launch8(8'd5, 8'd7, 8'd13);
    wait8(3, lat, bc, res8, to);
    check("ign_out", 256'(res8), 256'd1);
    check("ign_latency", 256'(lat), 256'd9);
    @(posedge clk); #1;
    check("ign_not_queued", 256'(bus8.busy), 256'd0);

    // Reset during LOOP iteration 4.
    launch8(8'd12, 8'd12, 8'd13);
    repeat (4) @(posedge clk);
    #1;
    rst8 = 1'b1;
    @(posedge clk); #1;
    rst8 = 1'b0;
    check("rst_mid_out", 256'(bus8.out), 256'd0);
    check("rst_mid_ready", 256'(bus8.out_ready), 256'd0);
    check("rst_mid_busy", 256'(bus8.busy), 256'd0);
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (bus8.out_ready) pulses++;
    end
    check("rst_mid_no_pulse", 256'(pulses), 256'd0);
    launch8(8'd9, 8'd9, 8'd13);
    wait8(-1, lat, bc, res8, to);
    check("rst_mid_recover", 256'(res8), 256'd9);

    // Random 8-bit operands against the reference model.
    for (int k = 0; k < 30; k++) begin
      n8 = 8'($urandom_range(1, 127) * 2 + 1);
      a8 = 8'($urandom_range(0, int'(n8) - 1));
      b8 = 8'($urandom_range(0, int'(n8) - 1));
      launch8(a8, b8, n8);
      wait8(-1, lat, bc, res8, to);
      check("rand8_out", 256'(res8), ref_mont(256'(a8), 256'(b8), 256'(n8), 8));
      check("rand8_latency", 256'(lat), 256'd9);
    end

    // Leaving the Montgomery domain: (M*2^256 mod N) * 1 recovers M.
    n = rand256();
    n[0] = 1'b1;
    n[255] = 1'b1;
    m = rand256() % n;
    wide = {m, 256'd0} % 512'(n);
    run256(wide[255:0], 256'd1, n, res, lat);
    check("pre_recover", res, m);
    check("pre_latency", 256'(lat), 256'd257);

    // Random 256-bit operands, mixing full-size and shorter moduli.
    for (int k = 0; k < 150; k++) begin
      n = rand256() >> $urandom_range(0, 250);
      n[0] = 1'b1;
      if (n < 256'd3) n = 256'd3;
      a = rand256() % n;
      b = rand256() % n;
      run256(a, b, n, res, lat);
      check("rand256_out", res, ref_mont(a, b, n, 256));
      check("rand256_latency", 256'(lat), 256'd257);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
